// File: rtl/pcs_link_ctrl.sv
// XAUI receive-link supervisor: sequences transceiver/PCS resets, waits for lock, sync and
// alignment, debounces into link_up, retries on timeout. Optional macro: PCS_LINK_CTRL_STATS_EN.
module pcs_link_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned RESET_PULSE    = 16,
   parameter int unsigned STABLE_CYCLES  = 255,
   parameter int unsigned MAX_RETRIES    = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rxlock,
   input  logic [3:0] signal_detect,
   input  logic [3:0] lanesync,
   input  logic       align_status,
   output logic       mgt_rx_reset,
   output logic       pcs_reset,
   output logic       link_up,
   output logic       link_fault,
   output logic [2:0] retry_count
`ifdef PCS_LINK_CTRL_STATS_EN
   ,
   output logic [15:0] loss_count
`endif
);

   typedef enum logic [2:0] {
      RESET_MGT,
      WAIT_LOCK,
      WAIT_SYNC,
      STABLE,
      UP,
      FAULT
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] RESET_LAST   = 16'(RESET_PULSE - 1);
   localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
   localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRIES);

   state_t      state;
   state_t      next_state;
   logic [15:0] timer;
   logic        lock_ok;
   logic        sync_ok;
   logic        retry_take;
   logic        retry_inc;
   logic        retry_clear;
   logic        fault_set;
   logic        fault_clear;
   logic        loss_event;
   logic        mgt_rx_reset_nxt;
   logic        pcs_reset_nxt;
   logic        link_up_nxt;

   assign lock_ok = (&rxlock) & (&signal_detect);
   assign sync_ok = lock_ok & (&lanesync) & align_status;

   // Condition checks are evaluated before the timeout so a good sample on the last cycle wins.
   always_comb begin
      next_state  = state;
      retry_take  = 1'b0;
      retry_inc   = 1'b0;
      retry_clear = 1'b0;
      fault_set   = 1'b0;
      fault_clear = 1'b0;
      loss_event  = 1'b0;
      case (state)
         RESET_MGT: begin
            if (timer == RESET_LAST)
               next_state = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_ok)
               next_state = WAIT_SYNC;
            else if (timer == TIMEOUT_LAST)
               retry_take = 1'b1;
         end
         WAIT_SYNC: begin
            if (!lock_ok)
               next_state = WAIT_LOCK;
            else if (sync_ok)
               next_state = STABLE;
            else if (timer == TIMEOUT_LAST)
               retry_take = 1'b1;
         end
         STABLE: begin
            if (!sync_ok)
               next_state = WAIT_SYNC;
            else if (timer == STABLE_LAST)
               next_state = UP;
         end
         UP: begin
            if (!lock_ok) begin
               next_state = RESET_MGT;
               loss_event = 1'b1;
            end else if (!sync_ok) begin
               next_state = WAIT_SYNC;
               loss_event = 1'b1;
            end
         end
         FAULT: begin
            if (timer == TIMEOUT_LAST) begin
               retry_clear = 1'b1;
               next_state  = RESET_MGT;
            end
         end
         default: next_state = RESET_MGT;
      endcase

      if (retry_take) begin
         if (retry_count == RETRY_LIMIT) begin
            next_state = FAULT;
            fault_set  = 1'b1;
         end else begin
            next_state = RESET_MGT;
            retry_inc  = 1'b1;
         end
      end

      if ((next_state == UP) && (state != UP)) begin
         retry_clear = 1'b1;
         fault_clear = 1'b1;
      end
   end

   // Outputs are decoded from the next state and registered, so they move with the state.
   always_comb begin
      mgt_rx_reset_nxt = 1'b0;
      pcs_reset_nxt    = 1'b0;
      link_up_nxt      = 1'b0;
      case (next_state)
         RESET_MGT: begin
            mgt_rx_reset_nxt = 1'b1;
            pcs_reset_nxt    = 1'b1;
         end
         WAIT_LOCK: pcs_reset_nxt = 1'b1;
         UP:        link_up_nxt   = 1'b1;
         FAULT: begin
            mgt_rx_reset_nxt = 1'b1;
            pcs_reset_nxt    = 1'b1;
         end
         default: begin
            mgt_rx_reset_nxt = 1'b0;
            pcs_reset_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RESET_MGT;
         timer        <= 16'd0;
         retry_count  <= 3'd0;
         link_fault   <= 1'b0;
         mgt_rx_reset <= 1'b1;
         pcs_reset    <= 1'b1;
         link_up      <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state != state)
            timer <= 16'd0;
         else if (timer != 16'hFFFF)
            timer <= timer + 16'd1;
         if (retry_clear)
            retry_count <= 3'd0;
         else if (retry_inc)
            retry_count <= retry_count + 3'd1;
         if (fault_set)
            link_fault <= 1'b1;
         else if (fault_clear)
            link_fault <= 1'b0;
         mgt_rx_reset <= mgt_rx_reset_nxt;
         pcs_reset    <= pcs_reset_nxt;
         link_up      <= link_up_nxt;
      end
   end

`ifdef PCS_LINK_CTRL_STATS_EN
   // Loss statistics survive retries and faults; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset)
         loss_count <= 16'd0;
      else if (loss_event && (loss_count != 16'hFFFF))
         loss_count <= loss_count + 16'd1;
   end
`else
   logic unused_loss;
   assign unused_loss = loss_event;
`endif

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Self-checking bench for pcs_link_ctrl: phase-based reference model compared every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_pcs_link_ctrl;

   localparam int RP = 16;
   localparam int SC = 8;
   localparam int TO = 100;
   localparam int MR = 2;

   localparam int P_RST   = 0;
   localparam int P_LOCK  = 1;
   localparam int P_SYNC  = 2;
   localparam int P_STAB  = 3;
   localparam int P_UP    = 4;
   localparam int P_FAULT = 5;

   logic       clk;
   logic       reset;
   logic [3:0] rxlock;
   logic [3:0] signal_detect;
   logic [3:0] lanesync;
   logic       align_status;
   logic       mgt_rx_reset;
   logic       pcs_reset;
   logic       link_up;
   logic       link_fault;
   logic [2:0] retry_count;
`ifdef PCS_LINK_CTRL_STATS_EN
   logic [15:0] loss_count;
`endif

   int total = 0;
   int bad   = 0;

   pcs_link_ctrl #(
      .TIMEOUT_CYCLES(TO),
      .RESET_PULSE   (RP),
      .STABLE_CYCLES (SC),
      .MAX_RETRIES   (MR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rxlock       (rxlock),
      .signal_detect(signal_detect),
      .lanesync     (lanesync),
      .align_status (align_status),
      .mgt_rx_reset (mgt_rx_reset),
      .pcs_reset    (pcs_reset),
      .link_up      (link_up),
      .link_fault   (link_fault),
      .retry_count  (retry_count)
`ifdef PCS_LINK_CTRL_STATS_EN
      ,
      .loss_count   (loss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] lk, input logic [3:0] sd,
                                input logic [3:0] ls, input logic al);
      rxlock        = lk;
      signal_detect = sd;
      lanesync      = ls;
      align_status  = al;
   endtask

   task automatic waitLinkUp(input int limit, output int cycles);
      cycles = -1;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (link_up === 1'b1) begin
            cycles = k;
            break;
         end
      end
   endtask

   // Reference model: phase plus cycles already spent in it, driven straight from the rules.
   int m_phase   = P_RST;
   int m_elapsed = 0;
   int m_retries = 0;
   int m_fault   = 0;
   int m_losses  = 0;
   bit m_valid   = 0;
   int m_next;
   bit m_lk;
   bit m_sy;
   bit m_timeout;

   always @(posedge clk) begin
      m_lk = (rxlock == 4'hF) && (signal_detect == 4'hF);
      m_sy = m_lk && (lanesync == 4'hF) && (align_status == 1'b1);
      if (reset) begin
         m_phase = P_RST; m_elapsed = 0; m_retries = 0; m_fault = 0; m_losses = 0; m_valid = 1;
      end else begin
         m_next    = m_phase;
         m_timeout = 0;
         case (m_phase)
            P_RST:  if (m_elapsed + 1 == RP) m_next = P_LOCK;
            P_LOCK: if (m_lk) m_next = P_SYNC; else if (m_elapsed + 1 == TO) m_timeout = 1;
            P_SYNC: if (!m_lk) m_next = P_LOCK; else if (m_sy) m_next = P_STAB;
                    else if (m_elapsed + 1 == TO) m_timeout = 1;
            P_STAB: if (!m_sy) m_next = P_SYNC; else if (m_elapsed + 1 == SC) m_next = P_UP;
            P_UP: begin
               if (!m_lk) m_next = P_RST; else if (!m_sy) m_next = P_SYNC;
               if (m_next != P_UP && m_losses < 65535) m_losses++;
            end
            default: if (m_elapsed + 1 == TO) begin m_retries = 0; m_next = P_RST; end
         endcase
         if (m_timeout) begin
            if (m_retries == MR) begin m_next = P_FAULT; m_fault = 1; end
            else begin m_retries++; m_next = P_RST; end
         end
         if (m_next == P_UP && m_phase != P_UP) begin m_retries = 0; m_fault = 0; end
         if (m_next != m_phase) m_elapsed = 0;
         else if (m_elapsed < 65535) m_elapsed++;
         m_phase = m_next;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         checkOutput("cmp_mgt", 16'(mgt_rx_reset), 16'((m_phase == P_RST) || (m_phase == P_FAULT)));
         checkOutput("cmp_pcs", 16'(pcs_reset),
                     16'((m_phase == P_RST) || (m_phase == P_LOCK) || (m_phase == P_FAULT)));
         checkOutput("cmp_up", 16'(link_up), 16'(m_phase == P_UP));
         checkOutput("cmp_fault", 16'(link_fault), 16'(m_fault));
         checkOutput("cmp_retry", 16'(retry_count), 16'(m_retries));
`ifdef PCS_LINK_CTRL_STATS_EN
         checkOutput("cmp_loss", loss_count, 16'(m_losses));
`endif
      end
   end

   int k;
   int mgt_hi;

   initial begin
      reset = 1'b1;
      applyStimulus(4'hF, 4'hF, 4'hF, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("rst_mgt", 16'(mgt_rx_reset), 16'd1);
      checkOutput("rst_pcs", 16'(pcs_reset), 16'd1);
      checkOutput("rst_up", 16'(link_up), 16'd0);
      checkOutput("rst_fault", 16'(link_fault), 16'd0);
      checkOutput("rst_retry", 16'(retry_count), 16'd0);

      $display("[TB] clean bring-up");
      reset  = 1'b0;
      mgt_hi = (mgt_rx_reset === 1'b1) ? 1 : 0;
      k      = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (link_up === 1'b1) begin k = c; break; end
         if (mgt_rx_reset === 1'b1) mgt_hi++;
      end
      checkOutput("bringup_cycles", 16'(k), 16'd26);
      checkOutput("bringup_mgt_hi", 16'(mgt_hi), 16'd16);
      checkOutput("bringup_retry", 16'(retry_count), 16'd0);

      $display("[TB] lane glitch in STABLE");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (22) @(negedge clk);
      applyStimulus(4'hF, 4'hF, 4'b1011, 1'b1);
      @(negedge clk);
      applyStimulus(4'hF, 4'hF, 4'hF, 1'b1);
      waitLinkUp(30, k);
      checkOutput("glitch_relock", 16'(k), 16'd9);
      checkOutput("glitch_retry", 16'(retry_count), 16'd0);

      $display("[TB] lock loss in UP");
      applyStimulus(4'b1110, 4'hF, 4'hF, 1'b1);
      @(negedge clk);
      checkOutput("lockloss_up", 16'(link_up), 16'd0);
      checkOutput("lockloss_mgt", 16'(mgt_rx_reset), 16'd1);
`ifdef PCS_LINK_CTRL_STATS_EN
      checkOutput("lockloss_count", loss_count, 16'd1);
`endif
      applyStimulus(4'hF, 4'hF, 4'hF, 1'b1);
      waitLinkUp(60, k);
      checkOutput("lockloss_relock", 16'(k), 16'd26);

      $display("[TB] align loss in UP, then sync on the last timeout cycle");
      applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
      @(negedge clk);
      checkOutput("alignloss_up", 16'(link_up), 16'd0);
      checkOutput("alignloss_mgt", 16'(mgt_rx_reset), 16'd0);
      checkOutput("alignloss_pcs", 16'(pcs_reset), 16'd0);
`ifdef PCS_LINK_CTRL_STATS_EN
      checkOutput("alignloss_count", loss_count, 16'd2);
`endif
      repeat (99) @(negedge clk);
      checkOutput("edge_retry_before", 16'(retry_count), 16'd0);
      applyStimulus(4'hF, 4'hF, 4'hF, 1'b1);
      waitLinkUp(30, k);
      checkOutput("edge_relock", 16'(k), 16'd9);
      checkOutput("edge_retry_after", 16'(retry_count), 16'd0);

      $display("[TB] reset pulse while UP");
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midup_mgt", 16'(mgt_rx_reset), 16'd1);
      checkOutput("midup_pcs", 16'(pcs_reset), 16'd1);
      checkOutput("midup_up", 16'(link_up), 16'd0);
      checkOutput("midup_retry", 16'(retry_count), 16'd0);
`ifdef PCS_LINK_CTRL_STATS_EN
      checkOutput("midup_loss", loss_count, 16'd0);
`endif
      reset = 1'b0;
      waitLinkUp(60, k);
      checkOutput("midup_relock", 16'(k), 16'd26);

      $display("[TB] lock never arrives");
      applyStimulus(4'b0111, 4'hF, 4'hF, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (115) @(negedge clk);
      checkOutput("nolock_retry0", 16'(retry_count), 16'd0);
      @(negedge clk);
      checkOutput("nolock_retry1", 16'(retry_count), 16'd1);
      checkOutput("nolock_mgt1", 16'(mgt_rx_reset), 16'd1);
      repeat (116) @(negedge clk);
      checkOutput("nolock_retry2", 16'(retry_count), 16'd2);
      repeat (116) @(negedge clk);
      checkOutput("fault_enter", 16'(link_fault), 16'd1);
      checkOutput("fault_mgt", 16'(mgt_rx_reset), 16'd1);
      checkOutput("fault_retry", 16'(retry_count), 16'd2);
      repeat (99) @(negedge clk);
      checkOutput("fault_last_retry", 16'(retry_count), 16'd2);
      @(negedge clk);
      checkOutput("fault_exit_retry", 16'(retry_count), 16'd0);
      checkOutput("fault_exit_sticky", 16'(link_fault), 16'd1);
      checkOutput("fault_exit_mgt", 16'(mgt_rx_reset), 16'd1);
      applyStimulus(4'hF, 4'hF, 4'hF, 1'b1);
      waitLinkUp(60, k);
      checkOutput("fault_relock", 16'(k), 16'd26);
      checkOutput("fault_cleared", 16'(link_fault), 16'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
